// File: rtl/sap_core_param.sv
// sap_core_param: parametrised SAP-class accumulator CPU.
// Instruction word is {opcode[3:0], operand[ADDR_W-1:0]}; data width is ADDR_W+4.
// Each instruction runs T1 (MAR<-PC), T2 (IR<-mem, PC++), T3 and, for memory
// operand instructions, T4. Program memory is loadable while in reset or halted.
module sap_core_param #(
  parameter  int ADDR_W = 4,
  localparam int W      = ADDR_W + 4
) (
  input  logic              sap_clock,
  input  logic              sap_reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [W-1:0]      prog_data,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic              halt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_HALTED
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_STA = 4'd3;
  localparam logic [3:0] OP_LDI = 4'd4;
  localparam logic [3:0] OP_JMP = 4'd5;
  localparam logic [3:0] OP_JC  = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   mar;
  logic [W-1:0]        ir;
  logic [W-1:0]        a;
  logic                c;
  logic                z;
  logic [W-1:0]        mem [DEPTH];

  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic [W-1:0]        mem_rd;
  logic [W:0]          sum;
  logic [W-1:0]        diff;
  logic                mem_op;

  assign opcode  = ir[W-1:ADDR_W];
  assign operand = ir[ADDR_W-1:0];
  assign mem_rd  = mem[mar];
  assign sum     = {1'b0, a} + {1'b0, mem_rd};
  assign diff    = a - mem_rd;
  assign mem_op  = (opcode == OP_LDA) || (opcode == OP_ADD) ||
                   (opcode == OP_SUB) || (opcode == OP_STA);

  // Sequencer state register; reset restarts fetch at T1.
  always_ff @(posedge sap_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (sap_reset) state <= ST_T1;
    else           state <= next_state;
  end

  // Next-state logic: memory-operand instructions take T4, HLT parks in HALTED.
  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      ST_T1:     next_state = ST_T2;
      ST_T2:     next_state = ST_T3;
      ST_T3: begin
        if (mem_op)                 next_state = ST_T4;
        else if (opcode == OP_HLT)  next_state = ST_HALTED;
        else                        next_state = ST_T1;
      end
      ST_T4:     next_state = ST_T1;
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_T1;
    endcase
  end

  // Datapath registers: fetch, execute and output strobe.
  always_ff @(posedge sap_clock) begin
    if (sap_reset) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a         <= '0;
      c         <= 1'b0;
      z         <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halt      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        ST_T1: mar <= pc;
        ST_T2: begin
          ir <= mem_rd;
          pc <= pc + ADDR_W'(1);
        end
        ST_T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
            OP_LDI: a  <= {4'b0000, operand};
            OP_JMP: pc <= operand;
            OP_JC:  if (c) pc <= operand;
            OP_JZ:  if (z) pc <= operand;
            OP_OUT: begin
              out_data  <= a;
              out_valid <= 1'b1;
            end
            OP_HLT: halt <= 1'b1;
            default: ;
          endcase
        end
        ST_T4: begin
          case (opcode)
            OP_LDA: a <= mem_rd;
            OP_ADD: begin
              {c, a} <= sum;
              z      <= (sum[W-1:0] == '0);
            end
            OP_SUB: begin
              a <= diff;
              c <= (a >= mem_rd);
              z <= (diff == '0);
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Program memory: external loads while reset/halted, STA write in T4.
  always_ff @(posedge sap_clock) begin
    // NOTE: memory has no reset branch; contents survive reset and a plain
    // RAM can be inferred.
    if (prog_we && (sap_reset || halt))
      mem[prog_addr] <= prog_data;
    else if (!sap_reset && state == ST_T4 && opcode == OP_STA)
      mem[mar] <= a;
  end

endmodule

// File: tb/tb_sap_core_param.sv
// Testbench for sap_core_param: an instruction-level model predicts, for every
// cycle after reset release, out_data/out_valid/halt; the DUT is compared each
// cycle, and a few hand-computed results pin the model itself.
module tb_sap_core_param;

  logic       clk;
  logic       rst;
  logic       we4;
  logic [3:0] pa4;
  logic [7:0] pd4;
  logic [7:0] od4;
  logic       ov4;
  logic       h4;
  logic       we5;
  logic [4:0] pa5;
  logic [8:0] pd5;
  logic [8:0] od5;
  logic       ov5;
  logic       h5;

  int checks   = 0;
  int failures = 0;

  int mmem [2][32];
  int pend [32];
  int ex_out  [256];
  int ex_val  [256];
  int ex_halt [256];

  int pulses, first_out, last_out, halt_cyc;

  sap_core_param #(.ADDR_W(4)) dut4 (
    .sap_clock(clk), .sap_reset(rst), .prog_we(we4), .prog_addr(pa4),
    .prog_data(pd4), .out_data(od4), .out_valid(ov4), .halt(h4)
  );

  sap_core_param #(.ADDR_W(5)) dut5 (
    .sap_clock(clk), .sap_reset(rst), .prog_we(we5), .prog_addr(pa5),
    .prog_data(pd5), .out_data(od5), .out_valid(ov5), .halt(h5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write one program word while reset is held; mirror it into the model memory.
  task automatic load(input int sel, input int addr, input int data);
    @(negedge clk);
    if (sel == 0) begin
      we4 = 1'b1; pa4 = addr[3:0]; pd4 = data[7:0];
    end else begin
      we5 = 1'b1; pa5 = addr[4:0]; pd5 = data[8:0];
    end
    mmem[sel][addr] = data;
    @(negedge clk);
    we4 = 1'b0;
    we5 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset out_data4", int'(od4), 0);
    check("reset out_valid4", int'(ov4), 0);
    check("reset halt4", int'(h4), 0);
    check("reset halt5", int'(h5), 0);
  endtask

  // Instruction-level model: runs the program from reset and records, per
  // cycle after release, what the three outputs must show.
  task automatic model(input int sel, output int hc);
    int aw, depth, mask, pc, a, c, z, s, instr, op, opd, sum;
    int m [32];
    aw    = (sel == 0) ? 4 : 5;
    depth = 1 << aw;
    mask  = (1 << (aw + 4)) - 1;
    for (int i = 0; i < 32; i++) m[i] = mmem[sel][i];
    for (int i = 0; i < 256; i++) begin
      ex_out[i] = 0; ex_val[i] = 0; ex_halt[i] = 0;
    end
    pc = 0; a = 0; c = 0; z = 0; s = 0; hc = -1;
    while (s < 240 && hc < 0) begin
      instr = m[pc];
      pc    = (pc + 1) % depth;
      op    = instr >> aw;
      opd   = instr & (depth - 1);
      case (op)
        0: begin a = m[opd]; s += 4; end
        1: begin
          sum = a + m[opd];
          c = (sum >> (aw + 4)) & 1;
          a = sum & mask;
          z = (a == 0);
          s += 4;
        end
        2: begin
          c = (a >= m[opd]) ? 1 : 0;
          a = (a - m[opd]) & mask;
          z = (a == 0);
          s += 4;
        end
        3: begin m[opd] = a; s += 4; end
        4: begin a = opd; s += 3; end
        5: begin pc = opd; s += 3; end
        6: begin if (c != 0) pc = opd; s += 3; end
        7: begin if (z != 0) pc = opd; s += 3; end
        14: begin
          for (int k = s + 3; k < 256; k++) ex_out[k] = a;
          ex_val[s + 3] = 1;
          s += 3;
        end
        15: begin
          hc = s + 3;
          for (int k = hc; k < 256; k++) ex_halt[k] = 1;
        end
        default: s += 3;
      endcase
    end
    for (int i = 0; i < 32; i++) pend[i] = m[i];
  endtask

  // Release reset and compare the DUT with the model every cycle. A stray
  // program write is driven for the first cycles when asked; abort_at >= 0
  // re-asserts reset after that cycle instead of running to the end.
  task automatic run(input int sel, input bit stray, input int abort_at);
    int hc, n, ao, av, ah;
    model(sel, hc);
    n = (hc >= 0) ? hc + 3 : 150;
    pulses = 0; first_out = -1; last_out = -1; halt_cyc = -1;
    rst = 1'b0;
    if (stray) begin
      we4 = 1'b1; pa4 = 4'd13; pd4 = 8'h77;
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (k == 6) we4 = 1'b0;
      ao = (sel == 0) ? int'(od4) : int'(od5);
      av = (sel == 0) ? int'(ov4) : int'(ov5);
      ah = (sel == 0) ? int'(h4)  : int'(h5);
      check($sformatf("dut%0d out_data c%0d", sel, k), ao, ex_out[k]);
      check($sformatf("dut%0d out_valid c%0d", sel, k), av, ex_val[k]);
      check($sformatf("dut%0d halt c%0d", sel, k), ah, ex_halt[k]);
      if (av != 0) begin
        pulses++;
        if (first_out < 0) first_out = ao;
        last_out = ao;
      end
      if (ah != 0 && halt_cyc < 0) halt_cyc = k;
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort out_data", int'(od4), 0);
        check("abort out_valid", int'(ov4), 0);
        check("abort halt", int'(h4), 0);
        return;
      end
    end
    we4 = 1'b0;
    for (int i = 0; i < 32; i++) mmem[sel][i] = pend[i];
  endtask

  initial begin
    rst = 1'b1;
    we4 = 1'b0; pa4 = '0; pd4 = '0;
    we5 = 1'b0; pa5 = '0; pd5 = '0;
    for (int i = 0; i < 16; i++) load(0, i, 'hF0);
    for (int i = 0; i < 32; i++) load(1, i, 'h1E0);
    check("initial out_valid4", int'(ov4), 0);
    check("initial halt4", int'(h4), 0);

    // Add and output: 0x1C + 0x0E = 0x2A, halt 14 cycles after release.
    load(0, 0, 'h0E); load(0, 1, 'h1F); load(0, 2, 'hE0); load(0, 3, 'hF0);
    load(0, 14, 'h1C); load(0, 15, 'h0E);
    run(0, 1'b0, -1);
    check("add out value", last_out, 'h2A);
    check("add pulses", pulses, 1);
    check("add halt cycle", halt_cyc, 14);

    // Carry and JC: 0xF0 + 0x20 -> A=0x10, C=1; JC taken, JZ not taken.
    do_reset();
    load(0, 0, 'h0E); load(0, 1, 'h1F); load(0, 2, 'h66); load(0, 3, 'h43);
    load(0, 4, 'hE0); load(0, 5, 'hF0); load(0, 6, 'h79); load(0, 7, 'hE0);
    load(0, 8, 'hF0); load(0, 9, 'h47); load(0, 10, 'hE0); load(0, 11, 'hF0);
    load(0, 14, 'hF0); load(0, 15, 'h20);
    run(0, 1'b0, -1);
    check("carry out value", last_out, 'h10);
    check("carry pulses", pulses, 1);
    check("carry halt cycle", halt_cyc, 20);

    // Zero and JZ: 5-5 -> A=0, Z=1, C=1 (both branches taken, output 3).
    do_reset();
    load(0, 0, 'h45); load(0, 1, 'h2F); load(0, 2, 'hE0); load(0, 3, 'h77);
    load(0, 4, 'h41); load(0, 5, 'hE0); load(0, 6, 'hF0); load(0, 7, 'h6B);
    load(0, 8, 'h42); load(0, 9, 'hE0); load(0, 10, 'hF0); load(0, 11, 'h43);
    load(0, 12, 'hE0); load(0, 13, 'hF0); load(0, 15, 'h05);
    run(0, 1'b0, -1);
    check("sub0 first out", first_out, 'h00);
    check("sub0 last out", last_out, 'h03);
    check("sub0 halt cycle", halt_cyc, 25);
    // 5-6 -> A=0xFF, C=0, Z=0 (JZ not taken, output 1).
    do_reset();
    load(0, 15, 'h06);
    run(0, 1'b0, -1);
    check("sub1 first out", first_out, 'hFF);
    check("sub1 last out", last_out, 'h01);
    check("sub1 pulses", pulses, 2);

    // STA round-trip through address 13.
    do_reset();
    load(0, 0, 'h49); load(0, 1, 'h3D); load(0, 2, 'h40); load(0, 3, 'h0D);
    load(0, 4, 'hE0); load(0, 5, 'hF0);
    run(0, 1'b0, -1);
    check("sta out value", last_out, 'h09);

    // PC wrap: NOP at 15 falls through to address 0 without halting.
    do_reset();
    load(0, 0, 'h62); load(0, 1, 'h5D); load(0, 2, 'hE0); load(0, 3, 'hF0);
    load(0, 12, 'hFF); load(0, 13, 'h41); load(0, 14, 'h1C); load(0, 15, 'h80);
    run(0, 1'b0, -1);
    check("wrap pulses", pulses, 1);
    check("wrap out value", last_out, 'h00);
    check("wrap halt cycle", halt_cyc, 25);

    // Reset during STA's T3: mem[13] keeps 0x33; stray writes while running ignored.
    do_reset();
    load(0, 13, 'h33);
    load(0, 0, 'h49); load(0, 1, 'hE0); load(0, 2, 'h3D); load(0, 3, 'hF0);
    run(0, 1'b0, 8);
    load(0, 0, 'h0D); load(0, 1, 'hE0); load(0, 2, 'hF0);
    run(0, 1'b1, -1);
    check("abort mem13 out", last_out, 'h33);
    check("abort pulses", pulses, 1);

    // Width generality: ADDR_W=5, 0x1FF + 0x001 -> A=0, C=1, Z=1; JMP 31.
    do_reset();
    load(1, 0, 'h01E); load(1, 1, 'h03D); load(1, 2, 'h0BF); load(1, 31, 'h0C3);
    load(1, 3, 'h0E5); load(1, 4, 'h1E0); load(1, 5, 'h1C0); load(1, 6, 'h1E0);
    load(1, 29, 'h001); load(1, 30, 'h1FF);
    run(1, 1'b0, -1);
    check("w9 out value", last_out, 'h000);
    check("w9 pulses", pulses, 1);
    check("w9 halt cycle", halt_cyc, 23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_core_param.md
# sap_core_param

Parametrised SAP-class accumulator CPU: the successor to the fixed 8-bit SAP-1 core. It generalises address/data width and adds a loadable program memory, store, immediate load, conditional jumps on carry/zero flags, and a registered output strobe. It is intended as a drop-in replacement under the same top-level bench, with the same clock, reset and `halt` semantics.

## Interface
- `ADDR_W`, default 4: address width; memory depth is 2**ADDR_W words.
- Derived, not overridable: word/data width `W = ADDR_W + 4`. The instruction word is `{opcode[3:0], operand[ADDR_W-1:0]}`.

Ports (one clock; reset is synchronous and active-high):
- `sap_clock`  in  1  clock; all state updates on the rising edge.
- `sap_reset`  in  1  synchronous, active-high reset.
- `prog_we`  in  1  program-memory write enable.
- `prog_addr`  in  ADDR_W  program write address.
- `prog_data`  in  W  program write data.
- `out_data`  out  W  output register.
- `out_valid`  out  1  one-cycle strobe; high in the cycle after an OUT updates `out_data`.
- `halt`  out  1  high once HLT has executed; stays high until reset.

## Operation
- Internal state:
  - PC (ADDR_W), MAR (ADDR_W), IR (W), A (W), flags C and Z.
  - Memory: 2**ADDR_W × W.
  - Sequencer states: T1, T2, T3, T4, HALTED.
- Reset values: PC=0, MAR=0, IR=0, A=0, C=0, Z=0, `out_data`=0, `out_valid`=0, `halt`=0, state=T1.
  - Memory is not cleared by reset.
- Program loading: `prog_we` writes `mem[prog_addr]` only in cycles where `sap_reset`=1 or `halt`=1. It is ignored otherwise.
- Fetch:
  - T1: MAR←PC.
  - T2: IR←mem[MAR]; PC←PC+1 (mod 2**ADDR_W; wrap from max to 0, no halt).
- Execute (T3, optionally T4). `op` means the zero-extended operand.
  - 0 LDA: T3 MAR←op; T4 A←mem[MAR].
  - 1 ADD: T3 MAR←op; T4 {C,A}←A+mem[MAR] (W+1-bit sum); Z←(A_new==0).
  - 2 SUB: T3 MAR←op; T4 A←A−mem[MAR] mod 2**W; C←(A_old ≥ mem) (no-borrow); Z←(A_new==0).
  - 3 STA: T3 MAR←op; T4 mem[MAR]←A.
  - 4 LDI: T3 A←op (zero-extended to W).
  - 5 JMP: T3 PC←op.
  - 6 JC: T3 PC←op if C=1, else no change.
  - 7 JZ: T3 PC←op if Z=1, else no change.
  - 14 OUT: T3 `out_data`←A; `out_valid`←1 for exactly the next cycle.
  - 15 HLT: T3 → HALTED; `halt`←1.
  - 8–13: NOP (T3 only).
- Flags are changed only by ADD and SUB.
- HALTED: no register or memory changes except `prog_we` writes. It is left only via reset.
- Simultaneous `prog_we` and STA cannot occur, because `prog_we` is gated off while running.

## Timing
- First T1 is the first rising edge with `sap_reset`=0.
- Instruction lengths:
  - LDA/ADD/SUB/STA: 4 cycles.
  - All other instructions: 3 cycles.
- `halt` rises on the edge ending HLT's T3 and is visible the following cycle.
- The `out_valid` pulse coincides with the first cycle in which the new `out_data` is visible.
- Reading `mem` in T2/T4 is a combinational read captured at the edge. Either async-read or a registered implementation with equivalent edge-visible timing is acceptable.
- Reset mid-instruction: reset aborts immediately at the reset edge.
  - All registers go to reset values.
  - Memory writes completed at earlier edges persist.
  - No partial STA occurs on the reset edge.

## Test plan
- **Add and output.** ADDR_W=4. Load mem[0]=0x0E (LDA 14), [1]=0x1F (ADD 15), [2]=0xE0, [3]=0xF0, [14]=0x1C, [15]=0x0E.
  - Release reset. Required: `out_data`=0x2A with a single `out_valid` pulse.
  - `halt`=1 exactly 14 cycles after reset release.
- **Carry and JC.** Program: LDA=0xF0, ADD 0x20, JC 6, then OUT/HLT at both paths.
  - Required: A=0x10, C=1, Z=0, and the taken path at address 6 outputs 0x10.
- **Zero and JZ.** Program: LDI 5, SUB (mem=0x05).
  - Required: A=0, Z=1, C=1; JZ taken.
  - Repeat with mem=0x06. Required: A=0xFF, C=0, Z=0; JZ not taken.
- **STA round-trip and wrap.**
  - LDI 9, STA 13, LDI 0, LDA 13, OUT. Required: `out_data`=0x09.
  - Separately, NOP at address 15 followed by JMP placement. Required: PC wraps 15→0 with no halt.
- **Reset mid-STA and gated programming.**
  - Assert reset during STA's T3. Required: target memory unchanged; all outputs at reset values next cycle.
  - Drive `prog_we` while running. Required: memory unchanged.
- **Width generality.** ADDR_W=5 (W=9). Add 0x1FF + 0x001.
  - Required: A=0x000, C=1, Z=1.
  - JMP 31 fetches from address 31.
